// File: rtl/block_fetch_responder.sv
// -----------------------------------------------------------------------------
// block_fetch_responder
//
// Fixed-latency backing-store model for a cache refill path. A request accepted
// in IDLE latches the word address, waits LATENCY edges, then presents the
// aligned 4-word block (and the requested word) with a one-cycle ready pulse.
// Memory content is synthetic: the word at address a is {17'b0, a}.
//
// Parameters
//   LATENCY      edges from accept edge to ready (1..15)
//   BLOCK_WORDS  words per returned block (4)
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   read_enable   in   block read request
//   address       in   [14:0] word address of the requested word
//   ready         out  one-cycle pulse, block data valid
//   busy          out  high in WAIT and DONE
//   all_data_out  out  [127:0] block, word k on bits [32k+31:32k]
//   data_out      out  [31:0] requested word within the block
//   read_count    out  [13:0] accepted-request counter (MEM_STATS_EN only)
//
// Build option: define MEM_STATS_EN to add the read_count port and counter.
// -----------------------------------------------------------------------------
module block_fetch_responder #(
    parameter int LATENCY     = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read_enable,
    input  logic [14:0]               address,
    output logic                      ready,
    output logic                      busy,
    output logic [32*BLOCK_WORDS-1:0] all_data_out,
    output logic [31:0]               data_out
`ifdef MEM_STATS_EN
    ,
    output logic [13:0]               read_count
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                      state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [14:0]                 addr_q, addr_d;
    logic [32*BLOCK_WORDS-1:0]   blk_q, blk_d;
    logic [31:0]                 word_q, word_d;
    logic                        accept;
    logic                        load_blk;

    // Block words are base+k; base is word-aligned so the low two bits are
    // simply k, which also guarantees no carry past 0x7FFF.
    always_comb begin
        blk_d = '0;
        for (int k = 0; k < BLOCK_WORDS; k++) begin
            blk_d[32*k +: 32] = {17'b0, addr_q[14:2], 2'(k)};
        end
        word_d = blk_d[{addr_q[1:0], 5'b0} +: 32];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        accept   = 1'b0;
        load_blk = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_enable) begin
                    accept  = 1'b1;
                    addr_d  = address;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    load_blk = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            blk_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if (load_blk) begin
                blk_q  <= blk_d;
                word_q <= word_d;
            end
        end
    end

    // Outputs decode straight from registered state so reset clears them
    // without waiting for an edge.
    assign ready        = (state_q == DONE);
    assign busy         = (state_q == WAIT) || (state_q == DONE);
    assign all_data_out = blk_q;
    assign data_out     = word_q;

`ifdef MEM_STATS_EN
    logic [13:0] rd_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rd_cnt_q <= '0;
        else if (accept) rd_cnt_q <= rd_cnt_q + 14'd1;
    end

    assign read_count = rd_cnt_q;
`else
    // accept only feeds the statistics counter
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: doc/block_fetch_responder.md
BLOCK_FETCH_RESPONDER -- requirements
Module: block_fetch_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning clock edges from request acceptance to ready; legal range 1..15.
REQ-002 The block SHALL have parameter BLOCK_WORDS, default 4, meaning words per returned block; fixed at 4.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 read_enable  input  1  block read request from the cache side.
REQ-006 address  input  15  word address of the requested word.
REQ-007 ready  output  1  one-cycle pulse; block data valid.
REQ-008 busy  output  1  high while a request is being serviced, DONE included.
REQ-009 all_data_out  output  128  returned block; word k on bits [32k+31:32k].
REQ-010 data_out  output  32  requested word within the block, selected by latched address[1:0].

Function
REQ-011 Memory contents SHALL be fixed: the word at address a equals {17'b0, a}.
REQ-012 The FSM SHALL have states IDLE, WAIT and DONE; reset state is IDLE.
REQ-013 In IDLE with read_enable=1, the block SHALL latch address, load the counter with LATENCY-1 and go to WAIT. This edge is the accept edge E0.
REQ-014 In WAIT, the counter SHALL decrement each edge; at counter 0 the FSM SHALL go to DONE and register the block data.
REQ-015 ready SHALL be 1 only in DONE, exactly one cycle, first visible after edge E0+LATENCY.
REQ-016 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-017 Block base SHALL be {latched address[14:2], 2'b00}; word k SHALL be base+k, k=0..3.
REQ-018 all_data_out and data_out SHALL hold their values from DONE until the next DONE.
REQ-019 read_enable SHALL be ignored in WAIT and DONE; there is no request queue.
REQ-020 With read_enable held high, back-to-back requests SHALL be accepted at the first IDLE edge after DONE; steady state is one request per LATENCY+2 cycles.
REQ-021 address changes after E0 SHALL NOT affect the returned data.
REQ-022 busy SHALL be 1 in WAIT and DONE and 0 in IDLE.
REQ-023 Block address 0x7FFC..0x7FFF SHALL return words 0x7FFC..0x7FFF with no wrap-around past 0x7FFF.

Reset
REQ-024 rst=1 SHALL immediately force the state to IDLE, the counter to 0, and ready, busy, all_data_out and data_out to 0, including mid-WAIT and mid-DONE.
REQ-025 A request in flight at reset SHALL be dropped, with no ready pulse after release.
REQ-026 After rst falls, the first rising edge with read_enable=1 SHALL be accepted.

Configuration
REQ-027 With MEM_STATS_EN defined, the block SHALL add output read_count (14 bits), reset to 0, incremented at each accept edge and wrapping 0x3FFF->0.
REQ-028 Without MEM_STATS_EN, the read_count port and its counter SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-029 Scenario, single read: LATENCY=4, read_enable pulse with address=0x0005 -> ready high exactly in the cycle after edge E0+4; all_data_out=0x00000007_00000006_00000005_00000004; data_out=0x00000005; busy high for 5 cycles.
REQ-030 Scenario, request ignored while busy: a second read_enable with address=0x0100 during WAIT -> ignored; data remains the 0x0004 block; only one ready pulse.
REQ-031 Scenario, back-to-back reads: read_enable held high, address=0x0010 then 0x0020 -> ready pulses 6 cycles apart; the second block has words 0x20..0x23.
REQ-032 Scenario, reset mid-operation: rst asserted 2 cycles after E0 -> outputs 0 at once; no ready pulse follows; the next request completes normally.
REQ-033 Scenario, top of address space: address=0x7FFE -> all_data_out=0x00007FFF_00007FFE_00007FFD_00007FFC; data_out=0x00007FFE.
REQ-034 Scenario, statistics: with MEM_STATS_EN defined, 3 completed requests -> read_count=3; after reset read_count=0.
